// File: rtl/i2c_slave_core.sv
// I2C target core: oversamples SCL/SDA on pclk, ACKs SLAVE_ADDR, delivers written
// bytes on rx_data/rx_valid and serves read bytes through a tx_req/tx_data handshake.
`timescale 1ns/1ps
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output logic       rw
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_buf_q;
  logic [7:0] rx_data_q, rx_data_d;
  logic       oe_q, oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never looks like a START.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_cond = scl_s & sda_prev_q & ~sda_s;
  assign stop_cond  = scl_s & ~sda_prev_q & sda_s;

  // NOTE: every _d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (start_cond) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      start_d = 1'b1;
      busy_d  = 1'b1;
    end else if (stop_cond) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_d     = shift_q[0];
              oe_d     = 1'b1;
              tx_req_d = shift_q[0];
              state_d  = ADDR_ACK;
            end else begin
              oe_d    = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              shift_d = tx_buf_q;
              oe_d    = ~tx_buf_q[7];
              state_d = RD_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d   = '0;
            oe_d    = 1'b1;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            cnt_d   = '0;
            oe_d    = 1'b0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = '0;
              oe_d    = 1'b0;
              state_d = RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          // Master ACK asks for another byte; NACK ends our part of the transfer.
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = IGNORE;
            end
          end else if (scl_fall) begin
            cnt_d   = '0;
            shift_d = tx_buf_q;
            oe_d    = ~tx_buf_q[7];
            state_d = RD_DATA;
          end
        end
        IGNORE:  oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      if (tx_req_q) tx_buf_q <= tx_data;
    end
  end

  assign sda_oe    = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign busy      = busy_q;
  assign rw        = rw_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-level I2C master model drives the bus,
// rx and read bytes are checked against scoreboard queues.
`timescale 1ns/1ps
module tb_i2c_slave_core;

  localparam time T = 40ns;

  logic       pclk = 1'b0;
  logic       preset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data_r = 8'h00;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, start_det, stop_det, busy, rw;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_core #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .preset(preset), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .tx_data(tx_data_r), .start_det(start_det),
    .stop_det(stop_det), .busy(busy), .rw(rw)
  );

  always #5 pclk = ~pclk;

  int         n_checks = 0, n_err = 0;
  int         rx_cnt = 0, txreq_cnt = 0, start_cnt = 0, stop_cnt = 0;
  bit         oe_seen = 0, busy_watch = 0, busy_drop = 0, tx_pop_pend = 0;
  logic [7:0] rx_exp[$], tx_src[$], rd_exp[$];
  logic [7:0] rx_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pulse counters, read-byte feeder and rx scoreboard, sampled mid-cycle.
  always @(negedge pclk) begin
    if (tx_pop_pend) begin
      tx_src.delete(0);
      tx_pop_pend = 0;
    end
    if (tx_req) begin
      txreq_cnt++;
      tx_pop_pend = 1;
    end
    tx_data_r = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
    if (rx_valid) begin
      rx_cnt++;
      if (rx_exp.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL rx_unexpected: observed 0x%0h expected none", rx_data);
      end else begin
        rx_e = rx_exp.pop_front();
        check("rx_data", {24'h0, rx_data}, {24'h0, rx_e});
      end
    end
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_seen = 1;
    if (busy_watch && !busy) busy_drop = 1;
  end

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    #T scl_m = 1'b1;
    #T s = sda_bus;
    #T scl_m = 1'b0;
    #T;
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    #T scl_m = 1'b1;
    #T sda_m = 1'b0;
    #T scl_m = 1'b0;
    #T;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #T scl_m = 1'b1;
    #T sda_m = 1'b1;
    #(3*T);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    sda_m = 1'b1;
    #T scl_m = 1'b1;
    #T check(tag, {30'h0, sda_oe, sda_bus}, {30'h0, exp_ack, ~exp_ack});
    #T scl_m = 1'b0;
    #T;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      v[i] = s;
    end
    clk_bit(ack, s);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    tx_src.push_back(b);
    rd_exp.push_back(b);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic       s;
    int         rx0, st0, sp0, tq0;

    // Reset state
    #23;
    check("reset_outputs", {17'h0, sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy, rw}, 32'h0);
    preset = 1'b1;
    #(4*T);

    // 1. Write 0x3C, 0xC3 to our address
    rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
    start_c();
    check("t1_start_pulse", start_cnt - st0, 1);
    check("t1_busy_high", {31'h0, busy}, 1);
    write_byte(8'hA0, 1'b1, "t1_addr_ack");
    check("t1_rw_write", {31'h0, rw}, 0);
    rx_exp.push_back(8'h3C);
    write_byte(8'h3C, 1'b1, "t1_data0_ack");
    rx_exp.push_back(8'hC3);
    write_byte(8'hC3, 1'b1, "t1_data1_ack");
    stop_c();
    check("t1_rx_pulses", rx_cnt - rx0, 2);
    check("t1_rx_drained", rx_exp.size(), 0);
    check("t1_stop_pulse", stop_cnt - sp0, 1);
    check("t1_busy_low", {31'h0, busy}, 0);

    // 2. Address mismatch
    rx0 = rx_cnt; sp0 = stop_cnt; tq0 = txreq_cnt;
    oe_seen = 0;
    start_c();
    write_byte(8'hA2, 1'b0, "t2_addr_nack");
    write_byte(8'h55, 1'b0, "t2_data_nack");
    stop_c();
    check("t2_oe_never", {31'h0, oe_seen}, 0);
    check("t2_no_rx", rx_cnt - rx0, 0);
    check("t2_no_txreq", txreq_cnt - tq0, 0);
    check("t2_stop_pulse", stop_cnt - sp0, 1);

    // 3. Read two bytes, ACK then NACK
    tq0 = txreq_cnt;
    queue_tx(8'h96);
    queue_tx(8'h5A);
    #(2*T);
    start_c();
    write_byte(8'hA1, 1'b1, "t3_addr_ack");
    check("t3_rw_read", {31'h0, rw}, 1);
    read_byte(1'b0, v);
    check("t3_rd_byte0", {24'h0, v}, {24'h0, rd_exp.pop_front()});
    read_byte(1'b1, v);
    check("t3_rd_byte1", {24'h0, v}, {24'h0, rd_exp.pop_front()});
    oe_seen = 0;
    #(4*T);
    check("t3_oe_after_nack", {31'h0, oe_seen}, 0);
    stop_c();
    check("t3_txreq_pulses", txreq_cnt - tq0, 2);
    check("t3_tx_drained", tx_src.size(), 0);

    // 4. Write then repeated START into a read
    rx0 = rx_cnt; st0 = start_cnt; tq0 = txreq_cnt;
    queue_tx(8'hE7);
    start_c();
    busy_drop = 0;
    busy_watch = 1;
    write_byte(8'hA0, 1'b1, "t4_addr_w_ack");
    rx_exp.push_back(8'h11);
    write_byte(8'h11, 1'b1, "t4_data_ack");
    start_c();
    write_byte(8'hA1, 1'b1, "t4_addr_r_ack");
    check("t4_rw_read", {31'h0, rw}, 1);
    read_byte(1'b1, v);
    check("t4_rd_byte", {24'h0, v}, {24'h0, rd_exp.pop_front()});
    busy_watch = 0;
    stop_c();
    check("t4_rx_once", rx_cnt - rx0, 1);
    check("t4_start_pulses", start_cnt - st0, 2);
    check("t4_busy_held", {31'h0, busy_drop}, 0);
    check("t4_txreq_once", txreq_cnt - tq0, 1);

    // 5. Asynchronous reset in the middle of a write data byte
    start_c();
    write_byte(8'hA0, 1'b1, "t5_addr_ack");
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    check("t5_pre_reset", {30'h0, busy, sda_oe}, 32'h2);
    #3 preset = 1'b0;
    #1;
    check("t5_reset_outputs", {17'h0, sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy, rw}, 32'h0);
    #30 preset = 1'b1;
    #(2*T);
    start_c();
    write_byte(8'hA0, 1'b1, "t5_readdr_ack");
    rx_exp.push_back(8'h77);
    write_byte(8'h77, 1'b1, "t5_data_ack");
    stop_c();
    check("t5_rx_data", {24'h0, rx_data}, 32'h77);

    // 6. STOP after three data bits, then a fresh transfer
    rx0 = rx_cnt; sp0 = stop_cnt;
    start_c();
    write_byte(8'hA0, 1'b1, "t6_addr_ack");
    clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    stop_c();
    check("t6_no_rx", rx_cnt - rx0, 0);
    check("t6_stop_pulse", stop_cnt - sp0, 1);
    check("t6_busy_low", {31'h0, busy}, 0);
    st0 = start_cnt;
    start_c();
    check("t6_restart", start_cnt - st0, 1);
    write_byte(8'hA0, 1'b1, "t6_readdr_ack");
    rx_exp.push_back(8'h42);
    write_byte(8'h42, 1'b1, "t6_data_ack");
    stop_c();
    check("t6_rx_data", {24'h0, rx_data}, 32'h42);
    check("t6_rx_drained", rx_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
